// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-subtractor cell feeds a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic            brw;

  logic            a_bit;
  logic            b_bit;
  logic            d_bit;
  logic            b_nxt;
  logic            last;
  logic            accept;

  assign a_bit  = sa[0];
  assign b_bit  = sb[0];
  assign d_bit  = a_bit ^ b_bit ^ brw;
  assign b_nxt  = (~a_bit & b_bit)
                | (~(a_bit ^ b_bit) & brw);
  assign last   = (state == RUN)
               && (cnt == CW'(WIDTH-1));
  assign accept = (state == IDLE) && start;

  // Next-state decode for the IDLE/RUN/DONE sequence
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register; busy/done registered from next state
  // so the handshake outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= (nxt != IDLE);
      done  <= (nxt == DONE);
    end
  end

  // Operand shifters, borrow, counter and result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      brw <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= {d_bit, sr[WIDTH-1:1]};
      brw <= b_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff       <= {d_bit, sr[WIDTH-1:1]};
        borrow_out <= b_nxt;
        // on the last bit a_bit/b_bit are the latched MSBs
        overflow   <= (a_bit != b_bit)
                   && (d_bit != a_bit);
      end
    end
  end

endmodule
